// File: rtl/umai_pkg.sv
// Shared types and flit header layout for the UMAI transmit striper.
package umai_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } umai_striper_state_e;

  localparam int unsigned SeqWidth     = 6;
  localparam int unsigned FlitLastBit  = 71;
  localparam int unsigned BurstLastBit = 70;
  localparam int unsigned SeqMsb       = 69;
  localparam int unsigned SeqLsb       = 64;

endpackage

// File: rtl/aib_flit_slot.sv
// One-entry valid/ready output register for a single AIB channel.
module aib_flit_slot #(
  parameter int unsigned Width = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [Width-1:0] data
);

  // A load wins over a drain, so the slot can hand off and refill in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/umai_tx_striper.sv
// Buffers one UMAI beat and stripes its flits round-robin over a contiguous
// group of AIB channels, each behind its own output register.
module umai_tx_striper
  import umai_pkg::*;
#(
  parameter int unsigned NumChannels  = 6,
  parameter int unsigned ChnWidth     = 72,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned BeatWidth    = 512,
  localparam int unsigned FlitsPerBeat = BeatWidth / PayloadWidth,
  localparam int unsigned ChnIdW       = $clog2(NumChannels)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 c_enable,
  input  logic [ChnIdW-1:0]                    c_first_chn_id,
  input  logic [ChnIdW-1:0]                    c_last_chn_id,
  input  logic                                 i_beat_valid,
  output logic                                 o_beat_ready,
  input  logic [BeatWidth-1:0]                 i_beat_data,
  input  logic                                 i_beat_last,
  output logic [NumChannels-1:0]               o_tx_valid,
  input  logic [NumChannels-1:0]               i_tx_ready,
  output logic [NumChannels-1:0][ChnWidth-1:0] o_tx_data,
  output logic                                 o_cfg_err,
  output logic                                 o_busy
);

  localparam int unsigned KW = $clog2(FlitsPerBeat);

  umai_striper_state_e state_q, state_d;

  logic [ChnIdW-1:0]    first_q, last_q, ptr_q;
  logic [SeqWidth-1:0]  seq_q;
  logic [KW-1:0]        k_q;
  logic                 buf_valid_q, buf_last_q;
  logic [BeatWidth-1:0] buf_data_q;
  logic                 cfg_err_q;

  logic                 cfg_valid, latch_cfg, issue, k_wrap, beat_accept, slots_empty;
  logic [ChnWidth-1:0]  flit;

  assign cfg_valid   = (c_first_chn_id <= c_last_chn_id) &&
                       ({1'b0, c_last_chn_id} < (ChnIdW+1)'(NumChannels));
  assign issue       = buf_valid_q && (!o_tx_valid[ptr_q] || i_tx_ready[ptr_q]);
  assign k_wrap      = (k_q == KW'(FlitsPerBeat - 1));
  assign o_beat_ready = (state_q == ACTIVE) && (!buf_valid_q || (issue && k_wrap));
  assign beat_accept = i_beat_valid && o_beat_ready;
  assign slots_empty = (o_tx_valid == '0);
  assign o_busy      = (state_q != IDLE);
  assign o_cfg_err   = cfg_err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c_enable && cfg_valid) begin
          state_d   = ACTIVE;
          latch_cfg = 1'b1;
        end
      end
      ACTIVE: begin
        if (!c_enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (!buf_valid_q && slots_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first_q     <= '0;
      last_q      <= '0;
      ptr_q       <= '0;
      seq_q       <= '0;
      k_q         <= '0;
      buf_valid_q <= 1'b0;
      buf_last_q  <= 1'b0;
      buf_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && c_enable && !cfg_valid;

      if (latch_cfg) begin
        first_q <= c_first_chn_id;
        last_q  <= c_last_chn_id;
        ptr_q   <= c_first_chn_id;
        seq_q   <= '0;
        k_q     <= '0;
      end else if (issue) begin
        ptr_q <= (ptr_q == last_q) ? first_q : ptr_q + 1'b1;
        seq_q <= seq_q + 1'b1;
        k_q   <= k_wrap ? '0 : k_q + 1'b1;
      end

      // A beat accepted on the final-flit cycle refills the buffer without a bubble.
      if (beat_accept) begin
        buf_valid_q <= 1'b1;
        buf_data_q  <= i_beat_data;
        buf_last_q  <= i_beat_last;
      end else if (issue && k_wrap) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    flit                              = '0;
    flit[PayloadWidth-1:0]            = buf_data_q[int'(k_q) * PayloadWidth +: PayloadWidth];
    flit[PayloadWidth +: SeqWidth]    = seq_q;
    flit[ChnWidth-2]                  = buf_last_q;
    flit[ChnWidth-1]                  = k_wrap;
  end

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_slot
    aib_flit_slot #(
      .Width(ChnWidth)
    ) u_slot (
      .clk      (i_clk),
      .rst      (i_rst),
      .load     (issue && (ptr_q == ChnIdW'(ch))),
      .load_data(flit),
      .ready    (i_tx_ready[ch]),
      .valid    (o_tx_valid[ch]),
      .data     (o_tx_data[ch])
    );
  end

endmodule
